msrv32_store_buffer: RTL and testbench

Posted write buffer between the store unit and the data-memory port. It accepts aligned store requests (data, address, byte mask) from the store unit and queues them in a small FIFO. It drains them to memory under a valid/ready handshake so a slow memory does not stall the core on every store. It raises stall when full, and raises a load-hazard stall when a pending store targets the word a load is about to read.

---
 rtl/msrv32_pkg.sv | 19 +
 rtl/msrv32_sb_fifo.sv | 76 +++++++
 rtl/msrv32_store_buffer.sv | 105 ++++++++++
 tb/tb_msrv32_store_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared types and field widths for the msrv32 store buffer.
// The drain state is informational; the datapath decodes everything from the entry count.
package msrv32_pkg;

    localparam int SB_MASK_W   = 4;
    localparam int SB_ADDR_LSB = 2;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_BUSY = 2'd1,
        SB_FULL = 2'd2
    } sb_state_e;

    // Word-address width: the byte offset within a 32-bit word is not stored.
    function automatic int sb_waddr_w(input int width);
        return width - SB_ADDR_LSB;
    endfunction

endpackage

// File: rtl/msrv32_sb_fifo.sv
// Circular DEPTH-entry FIFO of {data, word address, mask}.
// Exposes per-entry valid bits and word addresses so the top can compare a load against every pending store.
module msrv32_sb_fifo
    import msrv32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1,
    localparam int AW = sb_waddr_w(WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [WIDTH-1:0]              i_data,
    input  logic [AW-1:0]                 i_waddr,
    input  logic [SB_MASK_W-1:0]          i_mask,
    output logic [WIDTH-1:0]              o_data,
    output logic [AW-1:0]                 o_waddr,
    output logic [SB_MASK_W-1:0]          o_mask,
    output logic [CW-1:0]                 o_count,
    output logic [DEPTH-1:0]              o_valid,
    output logic [DEPTH-1:0][AW-1:0]      o_waddr_all
);

    logic [WIDTH-1:0]     r_data  [DEPTH];
    logic [AW-1:0]        r_waddr [DEPTH];
    logic [SB_MASK_W-1:0] r_mask  [DEPTH];
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i]  <= '0;
                r_waddr[i] <= '0;
                r_mask[i]  <= '0;
            end
        end else begin
            if (i_push) begin
                r_data[r_wr_ptr]  <= i_data;
                r_waddr[r_wr_ptr] <= i_waddr;
                r_mask[r_wr_ptr]  <= i_mask;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_data  = r_data[r_rd_ptr];
    assign o_waddr = r_waddr[r_rd_ptr];
    assign o_mask  = r_mask[r_rd_ptr];
    assign o_count = r_count;

    // An entry is live when its distance from the head (mod DEPTH) is below the count.
    always_comb begin
        logic [PW-1:0] w_off;
        w_off       = '0;
        o_valid     = '0;
        o_waddr_all = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off          = PW'(i) - r_rd_ptr;
            o_valid[i]     = ({1'b0, w_off} < r_count);
            o_waddr_all[i] = r_waddr[i];
        end
    end

endmodule

// File: rtl/msrv32_store_buffer.sv
// Posted write buffer between the store unit and the data-memory port.
// Qualifies pushes, detects load-after-store hazards and tracks the drain state.
module msrv32_store_buffer
    import msrv32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                 ms_riscv32_mp_clk_in,
    input  logic                 ms_riscv32_mp_rst_in,
    input  logic [WIDTH-1:0]     dmdata_in,
    input  logic [WIDTH-1:0]     dmaddr_in,
    input  logic [SB_MASK_W-1:0] dmwr_mask_in,
    input  logic                 dmwr_req_in,
    input  logic [WIDTH-1:0]     ld_addr_in,
    input  logic                 ld_req_in,
    input  logic                 ms_riscv32_mp_dm_ready_in,
    output logic [WIDTH-1:0]     ms_riscv32_mp_dmdata_out,
    output logic [WIDTH-1:0]     ms_riscv32_mp_dmaddr_out,
    output logic [SB_MASK_W-1:0] ms_riscv32_mp_dmwr_mask_out,
    output logic                 ms_riscv32_mp_dmwr_req_out,
    output logic                 st_stall_out,
    output logic                 ld_stall_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = sb_waddr_w(WIDTH);

    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_hit;
    logic [CW-1:0]            w_count;
    logic [CW-1:0]            w_count_next;
    logic [AW-1:0]            w_head_waddr;
    logic [DEPTH-1:0]         w_valid;
    logic [DEPTH-1:0][AW-1:0] w_waddr_all;
    logic                     w_unused_lsbs;
    sb_state_e                r_state;
    sb_state_e                w_state_next;

    // A full buffer refuses the push even if the head drains this same cycle.
    assign w_full = (w_count == CW'(DEPTH));
    assign w_push = dmwr_req_in && (|dmwr_mask_in) && !w_full;
    assign w_pop  = (w_count != '0) && ms_riscv32_mp_dm_ready_in;
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

    msrv32_sb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk         (ms_riscv32_mp_clk_in),
        .rst         (ms_riscv32_mp_rst_in),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_data      (dmdata_in),
        .i_waddr     (dmaddr_in[WIDTH-1:SB_ADDR_LSB]),
        .i_mask      (dmwr_mask_in),
        .o_data      (ms_riscv32_mp_dmdata_out),
        .o_waddr     (w_head_waddr),
        .o_mask      (ms_riscv32_mp_dmwr_mask_out),
        .o_count     (w_count),
        .o_valid     (w_valid),
        .o_waddr_all (w_waddr_all)
    );

    assign ms_riscv32_mp_dmaddr_out   = {w_head_waddr, {SB_ADDR_LSB{1'b0}}};
    assign ms_riscv32_mp_dmwr_req_out = (w_count != '0);
    assign st_stall_out               = w_full;

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_waddr_all[i] == ld_addr_in[WIDTH-1:SB_ADDR_LSB])) begin
                w_hit = 1'b1;
            end
        end
    end

    assign ld_stall_out  = ld_req_in && w_hit;
    assign w_unused_lsbs = ^{dmaddr_in[SB_ADDR_LSB-1:0], ld_addr_in[SB_ADDR_LSB-1:0]};

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state <= SB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            SB_IDLE: if (w_push) w_state_next = SB_BUSY;
            SB_BUSY: begin
                if (w_count_next == CW'(DEPTH)) w_state_next = SB_FULL;
                else if (w_count_next == '0)    w_state_next = SB_IDLE;
            end
            SB_FULL: if (w_pop) w_state_next = SB_BUSY;
            default: w_state_next = SB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_msrv32_store_buffer.sv
// Self-checking bench for msrv32_store_buffer: a per-cycle vector table plus
// hand-written sequences for ordering/wrap and asynchronous reset.
module tb_msrv32_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dmdata_in = '0;
    logic [31:0] dmaddr_in = '0;
    logic [3:0]  dmwr_mask_in = '0;
    logic        dmwr_req_in = 1'b0;
    logic [31:0] ld_addr_in = '0;
    logic        ld_req_in = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] dm_data;
    logic [31:0] dm_addr;
    logic [3:0]  dm_mask;
    logic        dm_req;
    logic        st_stall;
    logic        ld_stall;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    msrv32_store_buffer #(.DEPTH(4), .WIDTH(32)) dut (
        .ms_riscv32_mp_clk_in        (clk),
        .ms_riscv32_mp_rst_in        (rst),
        .dmdata_in                   (dmdata_in),
        .dmaddr_in                   (dmaddr_in),
        .dmwr_mask_in                (dmwr_mask_in),
        .dmwr_req_in                 (dmwr_req_in),
        .ld_addr_in                  (ld_addr_in),
        .ld_req_in                   (ld_req_in),
        .ms_riscv32_mp_dm_ready_in   (ready),
        .ms_riscv32_mp_dmdata_out    (dm_data),
        .ms_riscv32_mp_dmaddr_out    (dm_addr),
        .ms_riscv32_mp_dmwr_mask_out (dm_mask),
        .ms_riscv32_mp_dmwr_req_out  (dm_req),
        .st_stall_out                (st_stall),
        .ld_stall_out                (ld_stall)
    );

    typedef struct {
        logic        req;
        logic [31:0] data;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic        ldr;
        logic [31:0] lda;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_data;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic        e_st;
        logic        e_ld;
        logic        chk_f;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic req, input logic [31:0] data, input logic [31:0] addr,
                                input logic [3:0] mask, input logic ldr, input logic [31:0] lda,
                                input logic rdy, input logic e_req, input logic [31:0] e_data,
                                input logic [31:0] e_addr, input logic [3:0] e_mask,
                                input logic e_st, input logic e_ld, input logic chk_f);
        vec_t v;
        v.req = req; v.data = data; v.addr = addr; v.mask = mask;
        v.ldr = ldr; v.lda = lda; v.rdy = rdy;
        v.e_req = e_req; v.e_data = e_data; v.e_addr = e_addr; v.e_mask = e_mask;
        v.e_st = e_st; v.e_ld = e_ld; v.chk_f = chk_f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] data, input logic [31:0] addr,
                         input logic [3:0] mask, input logic ldr, input logic [31:0] lda,
                         input logic rdy);
        dmwr_req_in = req; dmdata_in = data; dmaddr_in = addr; dmwr_mask_in = mask;
        ld_req_in = ldr; ld_addr_in = lda; ready = rdy;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  mtab [10];
        logic [67:0] sb_q [$];
        logic [67:0] head;
        int pushed, got, mcount, cyc;
        logic acc_push, acc_pop;

        // Each row is one cycle: inputs applied after the falling edge, outputs checked before the rising edge.
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 0, 32'h0,    0, 0, 32'h0,        32'h0,    4'h0, 0, 0, 1));
        vq.push_back(mk(1, 32'hAB,       32'h1003, 4'h1, 0, 32'h0,    0, 0, 32'h0,        32'h0,    4'h0, 0, 0, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 0, 32'h0,    0, 1, 32'hAB,       32'h1000, 4'h1, 0, 0, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 0, 32'h0,    0, 1, 32'hAB,       32'h1000, 4'h1, 0, 0, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 0, 32'h0,    0, 1, 32'hAB,       32'h1000, 4'h1, 0, 0, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 0, 32'h0,    1, 1, 32'hAB,       32'h1000, 4'h1, 0, 0, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 0, 32'h0,    0, 0, 32'h0,        32'h0,    4'h0, 0, 0, 1));
        vq.push_back(mk(1, 32'h55,       32'h1100, 4'h0, 0, 32'h0,    0, 0, 32'h0,        32'h0,    4'h0, 0, 0, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 0, 32'h0,    0, 0, 32'h0,        32'h0,    4'h0, 0, 0, 1));
        vq.push_back(mk(1, 32'h11111111, 32'h2010, 4'hF, 0, 32'h0,    0, 0, 32'h0,        32'h0,    4'h0, 0, 0, 1));
        vq.push_back(mk(1, 32'h22,       32'h2014, 4'h3, 0, 32'h0,    0, 1, 32'h11111111, 32'h2010, 4'hF, 0, 0, 1));
        vq.push_back(mk(1, 32'h33,       32'h2018, 4'hC, 0, 32'h0,    0, 1, 32'h11111111, 32'h2010, 4'hF, 0, 0, 1));
        vq.push_back(mk(1, 32'h44,       32'h201C, 4'h1, 0, 32'h0,    0, 1, 32'h11111111, 32'h2010, 4'hF, 0, 0, 1));
        vq.push_back(mk(1, 32'h55,       32'h2000, 4'hF, 0, 32'h0,    0, 1, 32'h11111111, 32'h2010, 4'hF, 1, 0, 1));
        vq.push_back(mk(1, 32'h55,       32'h2000, 4'hF, 0, 32'h0,    1, 1, 32'h11111111, 32'h2010, 4'hF, 1, 0, 1));
        vq.push_back(mk(1, 32'h55,       32'h2000, 4'hF, 0, 32'h0,    0, 1, 32'h22,       32'h2014, 4'h3, 0, 0, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 1, 32'h2002, 0, 1, 32'h22,       32'h2014, 4'h3, 1, 1, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 1, 32'h2024, 0, 1, 32'h22,       32'h2014, 4'h3, 1, 0, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 0, 32'h0,    1, 1, 32'h22,       32'h2014, 4'h3, 1, 0, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 0, 32'h0,    1, 1, 32'h33,       32'h2018, 4'hC, 0, 0, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 0, 32'h0,    1, 1, 32'h44,       32'h201C, 4'h1, 0, 0, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 1, 32'h2000, 1, 1, 32'h55,       32'h2000, 4'hF, 0, 1, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 1, 32'h2000, 0, 0, 32'h0,        32'h0,    4'h0, 0, 0, 0));
        vq.push_back(mk(1, 32'h99,       32'h3004, 4'hF, 0, 32'h0,    0, 0, 32'h0,        32'h0,    4'h0, 0, 0, 0));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 1, 32'h3006, 0, 1, 32'h99,       32'h3004, 4'hF, 0, 1, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 1, 32'h3008, 0, 1, 32'h99,       32'h3004, 4'hF, 0, 0, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 1, 32'h3006, 1, 1, 32'h99,       32'h3004, 4'hF, 0, 1, 1));
        vq.push_back(mk(0, 32'h0,        32'h0,    4'h0, 1, 32'h3006, 0, 0, 32'h0,        32'h0,    4'h0, 0, 0, 0));

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            logic [127:0] act, exp;
            if (i != 0) @(negedge clk);
            drive(vq[i].req, vq[i].data, vq[i].addr, vq[i].mask, vq[i].ldr, vq[i].lda, vq[i].rdy);
            #2;
            act = {dm_req, st_stall, ld_stall};
            exp = {vq[i].e_req, vq[i].e_st, vq[i].e_ld};
            if (vq[i].chk_f) begin
                act = {act[2:0], dm_data, dm_addr, dm_mask};
                exp = {exp[2:0], vq[i].e_data, vq[i].e_addr, vq[i].e_mask};
            end
            chk($sformatf("row%0d", i), act, exp);
        end

        // Ordering and pointer wrap: a store unit re-presenting refused pushes against a toggling ready.
        mtab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h5, 4'hA, 4'h6};
        pushed = 0; got = 0; mcount = 0; cyc = 0;
        while ((pushed < 10 || mcount > 0) && cyc < 200) begin
            @(negedge clk);
            drive(pushed < 10, 32'hD0 + 32'(pushed), 32'h100 + 32'(4 * pushed) + 32'(pushed % 4),
                  (pushed < 10) ? mtab[pushed % 10] : 4'h0, 0, 32'h0, (cyc % 2) == 0);
            #2;
            chk($sformatf("order_req_c%0d", cyc), {127'd0, dm_req}, {127'd0, mcount != 0});
            chk($sformatf("order_st_c%0d", cyc), {127'd0, st_stall}, {127'd0, mcount == 4});
            if (mcount > 0) begin
                head = sb_q[0];
                chk($sformatf("order_head_c%0d", cyc), {60'd0, dm_data, dm_addr, dm_mask}, {60'd0, head});
            end
            acc_pop  = (mcount > 0) && ready;
            acc_push = dmwr_req_in && (mcount < 4);
            if (acc_pop) begin
                void'(sb_q.pop_front());
                got++;
            end
            if (acc_push) begin
                sb_q.push_back({32'hD0 + 32'(pushed), 32'h100 + 32'(4 * pushed), mtab[pushed % 10]});
                pushed++;
            end
            mcount = mcount + int'(acc_push) - int'(acc_pop);
            cyc++;
        end
        chk("order_drained", {96'd0, 32'(got)}, {96'd0, 32'd10});

        // Asynchronous reset with three entries pending and memory stalled.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 32'h400 + 32'(i), 32'h400 + 32'(4 * i), 4'hF, 0, 32'h0, 0);
        end
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 4'h0, 1, 32'h404, 0);
        #2;
        chk("rst_pre", {126'd0, dm_req, ld_stall}, {126'd0, 1'b1, 1'b1});
        rst = 1'b1;
        #1;
        chk("rst_async", {60'd0, dm_req, st_stall, ld_stall, dm_data, dm_addr, dm_mask, 1'b0},
                         {60'd0, 3'b000, 32'h0, 32'h0, 4'h0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'h77, 32'h500, 4'h8, 0, 32'h0, 0);
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1);
        #2;
        chk("rst_after_push", {59'd0, dm_req, dm_data, dm_addr, dm_mask}, {59'd0, 1'b1, 32'h77, 32'h500, 4'h8});
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0);
        #2;
        chk("rst_empty_after", {126'd0, dm_req, st_stall}, {126'd0, 2'b00});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
